// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory image loader: state encodings,
// default frame marker and a helper that classifies mid-frame states.
package imem_loader_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_ADDR_LO = 4'd1,
    ST_ADDR_HI = 4'd2,
    ST_LEN_LO  = 4'd3,
    ST_LEN_HI  = 4'd4,
    ST_DATA    = 4'd5,
    ST_CSUM    = 4'd6,
    ST_DONE    = 4'd7,
    ST_ERR     = 4'd8
  } state_t;

  // States in which the idle-cycle watchdog is armed.
  function automatic logic timed_state(state_t s);
    return !(s == ST_IDLE || s == ST_DONE || s == ST_ERR);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Valid/ready byte stream feeding the loader; master is the byte source.
interface imem_loader_if;
  logic [7:0] in_byte;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_byte, output in_valid, input in_ready);
  modport slave  (input in_byte, input in_valid, output in_ready);
endinterface

// File: rtl/imem_loader_csum.sv
// Running XOR of the payload bytes of the current frame, with a compare port
// used to judge the trailing checksum byte.
module loader_csum (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       upd,
  input  logic [7:0] data,
  output logic       ok
);

  logic [7:0] xor_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xor_q <= 8'h00;
    end else if (clr) begin
      xor_q <= 8'h00;
    end else if (upd) begin
      xor_q <= xor_q ^ data;
    end
  end

  assign ok = (data == xor_q);

endmodule

// File: rtl/imem_loader.sv
// Frames a program image from a byte stream into instruction memory and holds
// the CPU until a complete image with a matching checksum has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          ADDR_W      = 16,
  parameter int          MEM_DEPTH   = 1024,
  parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter int          TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  imem_loader_if.slave      bus,
  output logic              imem_wEn,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [7:0]        imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W-1:0] bytes_loaded
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_t            state, state_nx;
  logic              accept, is_sync, csum_ok, range_bad, last_data, tmo_expire;
  logic [7:0]        addr_lo, len_lo;
  logic [ADDR_W-1:0] start, len, count, len_full;
  logic [ADDR_W:0]   end_addr;
  logic [TW-1:0]     tmo_cnt;
  logic              wr_vld_p1;
  logic [ADDR_W-1:0] wr_addr_p1;
  logic [7:0]        wr_data_p1;

  assign bus.in_ready = (state != ST_DONE) && (state != ST_ERR);
  assign accept       = bus.in_valid && bus.in_ready;
  assign is_sync      = (bus.in_byte == SYNC_BYTE);
  assign len_full     = ADDR_W'({bus.in_byte, len_lo});
  // Range check at one extra bit so a start near the top cannot wrap.
  assign end_addr     = {1'b0, start} + {1'b0, len_full};
  assign range_bad    = end_addr > (ADDR_W+1)'(MEM_DEPTH);
  assign last_data    = (count + ADDR_W'(1)) == len;
  // An accepted byte on the expiry cycle wins: expiry needs in_valid low.
  assign tmo_expire   = timed_state(state) && !bus.in_valid &&
                        (tmo_cnt == TW'(TIMEOUT_CYC - 1));

  loader_csum u_csum (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept && state == ST_IDLE && is_sync),
    .upd   (accept && state == ST_DATA),
    .data  (bus.in_byte),
    .ok    (csum_ok)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (tmo_expire) begin
      state_nx = ST_ERR;
    end else begin
      case (state)
        ST_IDLE:    if (accept && is_sync) state_nx = ST_ADDR_LO;
        ST_ADDR_LO: if (accept) state_nx = ST_ADDR_HI;
        ST_ADDR_HI: if (accept) state_nx = ST_LEN_LO;
        ST_LEN_LO:  if (accept) state_nx = ST_LEN_HI;
        ST_LEN_HI:  if (accept) state_nx = range_bad ? ST_ERR :
                                           (len_full == '0) ? ST_CSUM : ST_DATA;
        ST_DATA:    if (accept && last_data) state_nx = ST_CSUM;
        ST_CSUM:    if (accept) state_nx = csum_ok ? ST_DONE : ST_ERR;
        ST_DONE:    state_nx = ST_DONE;
        ST_ERR:     state_nx = ST_IDLE;
        default:    state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_lo      <= '0;
      len_lo       <= '0;
      start        <= '0;
      len          <= '0;
      count        <= '0;
      tmo_cnt      <= '0;
      wr_vld_p1    <= 1'b0;
      wr_addr_p1   <= '0;
      wr_data_p1   <= '0;
      bytes_loaded <= '0;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
    end else begin
      wr_vld_p1 <= 1'b0;
      if (!timed_state(state) || bus.in_valid) tmo_cnt <= '0;
      else                                     tmo_cnt <= tmo_cnt + TW'(1);
      if (accept) begin
        case (state)
          ST_IDLE: if (is_sync) begin
            load_err     <= 1'b0;
            bytes_loaded <= '0;
          end
          ST_ADDR_LO: addr_lo <= bus.in_byte;
          ST_ADDR_HI: start   <= ADDR_W'({bus.in_byte, addr_lo});
          ST_LEN_LO:  len_lo  <= bus.in_byte;
          ST_LEN_HI: begin
            len   <= len_full;
            count <= '0;
          end
          // ---- stage p1: write register, imem sees it the cycle after accept
          ST_DATA: begin
            wr_vld_p1    <= 1'b1;
            wr_addr_p1   <= start + count;
            wr_data_p1   <= bus.in_byte;
            count        <= count + ADDR_W'(1);
            bytes_loaded <= bytes_loaded + ADDR_W'(1);
          end
          default: ;
        endcase
      end
      if (state_nx == ST_ERR && state != ST_ERR) load_err <= 1'b1;
      if (state_nx == ST_DONE && state == ST_CSUM) load_done <= 1'b1;
    end
  end

  assign imem_wEn   = wr_vld_p1;
  assign imem_addr  = wr_addr_p1;
  assign imem_wdata = wr_data_p1;
  assign cpu_hold   = !load_done;

endmodule
